// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - producer/consumer handshake bundle for fifo_sync_param
interface fifo_sync_param_if #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic          WR_EN;
   logic [DW-1:0] FIFO_IN;
   logic          RD_EN;
   logic          CLR_ERR;
   logic [DW-1:0] FIFO_OUT;
   logic          EMPTY;
   logic          FULL;
   logic          ALMOST_FULL;
   logic          ALMOST_EMPTY;
   logic [AW:0]   COUNT;
   logic          OVF;
   logic          UDF;

   modport master (
      output WR_EN, FIFO_IN, RD_EN, CLR_ERR,
      input  FIFO_OUT, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVF, UDF
   );

   modport slave (
      input  WR_EN, FIFO_IN, RD_EN, CLR_ERR,
      output FIFO_OUT, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVF, UDF
   );
endinterface

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with fill level, threshold flags and sticky errors
// Pointers carry an extra wrap bit so FULL/EMPTY are told apart without a separate flag.
module fifo_sync_param #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int AF_TH = DEPTH - 2,
   parameter int AE_TH = 2,
   parameter int FWFT  = 0
) (
   input  logic               SYSCLK,
   input  logic               RST_B,
   fifo_sync_param_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE    = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] AF_LVL = (AW+1)'(AF_TH);
   localparam logic [AW:0] AE_LVL = (AW+1)'(AE_TH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          empty, full, rd_ok, wr_ok;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign rd_ok = bus.RD_EN & ~empty;
   // A concurrent accepted read frees the slot, so a write on FULL still lands.
   assign wr_ok = bus.WR_EN & (~full | rd_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + ONE;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + ONE;
         2'b01:   count_d = count_q - ONE;
         default: count_d = count_q;
      endcase
      // New error events take priority over the clear.
      ovf_d = (bus.WR_EN & ~wr_ok) | (ovf_q & ~bus.CLR_ERR);
      udf_d = (bus.RD_EN & empty)  | (udf_q & ~bus.CLR_ERR);
   end

   always_ff @(posedge SYSCLK or negedge RST_B) begin
      if (!RST_B) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge SYSCLK or negedge RST_B) begin
      if (!RST_B) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.FIFO_IN;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign bus.FIFO_OUT = mem_q[rd_ptr_q[AW-1:0]];
      end else begin : g_reg
         logic [DW-1:0] dout_q;
         always_ff @(posedge SYSCLK or negedge RST_B) begin
            if (!RST_B)     dout_q <= '0;
            else if (rd_ok) dout_q <= mem_q[rd_ptr_q[AW-1:0]];
         end
         assign bus.FIFO_OUT = dout_q;
      end
   endgenerate

   assign bus.EMPTY        = empty;
   assign bus.FULL         = full;
   assign bus.COUNT        = count_q;
   assign bus.ALMOST_FULL  = (count_q >= AF_LVL);
   assign bus.ALMOST_EMPTY = (count_q <= AE_LVL);
   assign bus.OVF          = ovf_q;
   assign bus.UDF          = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - self-checking bench for fifo_sync_param (registered and FWFT builds)
module tb_fifo_sync_param;
   typedef struct {
      logic       wr;
      logic [7:0] din;
      logic       rd;
      logic       clr;
      int         cnt;
      logic       e, f, af, ae, ov, ud;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fifo_sync_param_if #(.DW(8),  .DEPTH(16)) bus_a ();
   fifo_sync_param_if #(.DW(16), .DEPTH(4))  bus_b ();

   fifo_sync_param #(.DW(8), .DEPTH(16)) dut_a (
      .SYSCLK (clk),
      .RST_B  (rst_n),
      .bus    (bus_a)
   );

   fifo_sync_param #(.DW(16), .DEPTH(4), .AF_TH(2), .AE_TH(2), .FWFT(1)) dut_b (
      .SYSCLK (clk),
      .RST_B  (rst_n),
      .bus    (bus_b)
   );

   int n_vec = 0;
   int n_bad = 0;
   vec_t tbl[$];
   logic [7:0]  mq_a[$];
   logic [7:0]  exp_a[$];
   logic [7:0]  last_a = 8'h00;
   logic [15:0] mq_b[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [7:0] din, input logic rd, input logic clr,
                               input int cnt, input logic e, input logic f, input logic af,
                               input logic ae, input logic ov, input logic ud);
      vec_t v;
      v.wr = wr; v.din = din; v.rd = rd; v.clr = clr; v.cnt = cnt;
      v.e = e; v.f = f; v.af = af; v.ae = ae; v.ov = ov; v.ud = ud;
      return v;
   endfunction

   task automatic chk_a(input string tag, input int cnt, input logic e, input logic f, input logic af,
                        input logic ae, input logic ov, input logic ud);
      chk({tag, ".count"}, 32'(bus_a.COUNT), cnt);
      chk({tag, ".empty"}, 32'(bus_a.EMPTY), 32'(e));
      chk({tag, ".full"},  32'(bus_a.FULL), 32'(f));
      chk({tag, ".afull"}, 32'(bus_a.ALMOST_FULL), 32'(af));
      chk({tag, ".aempty"}, 32'(bus_a.ALMOST_EMPTY), 32'(ae));
      chk({tag, ".ovf"},   32'(bus_a.OVF), 32'(ov));
      chk({tag, ".udf"},   32'(bus_a.UDF), 32'(ud));
   endtask

   // Called at a falling edge; returns at the next falling edge with outputs settled.
   task automatic step_a(input string tag, input logic wr, input logic [7:0] din,
                         input logic rd, input logic clr);
      logic rd_m, wr_m;
      bus_a.WR_EN = wr; bus_a.FIFO_IN = din; bus_a.RD_EN = rd; bus_a.CLR_ERR = clr;
      rd_m = rd && (mq_a.size() != 0);
      wr_m = wr && ((mq_a.size() < 16) || rd_m);
      if (rd_m) exp_a.push_back(mq_a.pop_front());
      if (wr_m) mq_a.push_back(din);
      @(posedge clk);
      @(negedge clk);
      bus_a.WR_EN = 1'b0; bus_a.RD_EN = 1'b0; bus_a.CLR_ERR = 1'b0;
      if (rd_m) last_a = exp_a.pop_front();
      chk({tag, ".dout"}, 32'(bus_a.FIFO_OUT), 32'(last_a));
   endtask

   task automatic step_b(input string tag, input logic wr, input logic [15:0] din, input logic rd,
                         input int cnt, input logic f, input logic af, input logic ae);
      bus_b.WR_EN = wr; bus_b.FIFO_IN = din; bus_b.RD_EN = rd; bus_b.CLR_ERR = 1'b0;
      if (rd && mq_b.size() != 0) void'(mq_b.pop_front());
      if (wr && mq_b.size() < 4) mq_b.push_back(din);
      @(posedge clk);
      @(negedge clk);
      bus_b.WR_EN = 1'b0; bus_b.RD_EN = 1'b0;
      chk({tag, ".count"}, 32'(bus_b.COUNT), cnt);
      chk({tag, ".empty"}, 32'(bus_b.EMPTY), 32'(cnt == 0));
      chk({tag, ".full"},  32'(bus_b.FULL), 32'(f));
      chk({tag, ".afull"}, 32'(bus_b.ALMOST_FULL), 32'(af));
      chk({tag, ".aempty"}, 32'(bus_b.ALMOST_EMPTY), 32'(ae));
      if (cnt != 0 && mq_b.size() != 0) chk({tag, ".head"}, 32'(bus_b.FIFO_OUT), 32'(mq_b[0]));
   endtask

   initial begin
      rst_n = 1'b0;
      bus_a.WR_EN = 1'b0; bus_a.FIFO_IN = '0; bus_a.RD_EN = 1'b0; bus_a.CLR_ERR = 1'b0;
      bus_b.WR_EN = 1'b0; bus_b.FIFO_IN = '0; bus_b.RD_EN = 1'b0; bus_b.CLR_ERR = 1'b0;

      // Registered-read vector table: fill, overflow, write-through-full, drain, underflow, clears.
      for (int i = 0; i < 16; i++)
         tbl.push_back(mk(1'b1, 8'(i + 1), 1'b0, 1'b0, i + 1, 1'b0, i == 15, (i + 1) >= 14, (i + 1) <= 2, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 8'hBB, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      for (int k = 1; k <= 16; k++)
         tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 16 - k, k == 16, 1'b0, (16 - k) >= 14, (16 - k) <= 2, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 8'h77, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

      repeat (2) @(negedge clk);
      chk_a("rst", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rst.dout", 32'(bus_a.FIFO_OUT), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_a("idle", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("idle.dout", 32'(bus_a.FIFO_OUT), 32'h0);

      foreach (tbl[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         step_a(tag, tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].clr);
         chk_a(tag, tbl[i].cnt, tbl[i].e, tbl[i].f, tbl[i].af, tbl[i].ae, tbl[i].ov, tbl[i].ud);
      end

      // Steady occupancy of 5 while pointers wrap several times.
      for (int i = 0; i < 5; i++) step_a("wrap_fill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      chk_a("wrap_fill", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step_a($sformatf("wrap%0d", i), 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
         chk_a($sformatf("wrap%0d", i), 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int k = 4; k >= 0; k--) begin
         step_a("drain", 1'b0, 8'h00, 1'b1, 1'b0);
         chk_a($sformatf("drain%0d", k), k, k == 0, 1'b0, 1'b0, k <= 2, 1'b0, 1'b0);
      end

      // Asynchronous reset in the middle of a write burst.
      step_a("pre_rst", 1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step_a("pre_rst", 1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
      step_a("pre_rst", 1'b0, 8'h00, 1'b1, 1'b0);
      chk_a("pre_rst", 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      bus_a.WR_EN = 1'b1; bus_a.FIFO_IN = 8'h99;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_a("async_rst", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("async_rst.dout", 32'(bus_a.FIFO_OUT), 32'h0);
      mq_a.delete(); exp_a.delete(); last_a = 8'h00;
      bus_a.WR_EN = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // FWFT build: DW=16, DEPTH=4, AF_TH=2.
      chk("b_rst.empty", 32'(bus_b.EMPTY), 32'h1);
      step_b("b_wr", 1'b1, 16'h1234, 1'b0, 1, 1'b0, 1'b0, 1'b1);
      chk("b_wr.dout", 32'(bus_b.FIFO_OUT), 32'h1234);
      step_b("b_hold", 1'b0, 16'h0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
      chk("b_hold.dout", 32'(bus_b.FIFO_OUT), 32'h1234);
      step_b("b_rd", 1'b0, 16'h0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++)
         step_b($sformatf("b_fill%0d", i), 1'b1, 16'(16'hA000 + i), 1'b0, i + 1, i == 3, (i + 1) >= 2, (i + 1) <= 2);
      for (int k = 3; k >= 0; k--)
         step_b($sformatf("b_drain%0d", k), 1'b0, 16'h0, 1'b1, k, 1'b0, k >= 2, k <= 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
